ones_count_ctrl: RTL and testbench
==================================

ONES_COUNT_CTRL -- requirements
Module: ones_count_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: bit width of the operand word.
REQ-002 Parameter BITS_PER_CYCLE, default 1: operand bits consumed per RUN beat; legal values 1, 2, 4, 8; WIDTH SHALL be an integer multiple of it.
REQ-003 Localparam CW = $clog2(WIDTH+1), 6 for WIDTH=32, SHALL size the count so a full-ones word is representable.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to count the word on data; sampled only in IDLE.
REQ-007 data  input  WIDTH  operand; captured on the edge that accepts start; later changes have no effect.
REQ-008 abort  input  1  cancels a count in progress; acts only in RUN.
REQ-009 ack  input  1  consumer acknowledge of a completed result; acts only in DONE.
REQ-010 ready  output  1  high exactly when the state is IDLE.
REQ-011 busy  output  1  high exactly when the state is RUN.
REQ-012 done  output  1  high exactly when the state is DONE.
REQ-013 count  output  CW  last completed result; registered.

Function
REQ-014 Registered FSM states: IDLE, RUN, DONE; outputs decoded from state only, with no combinational path from inputs to outputs.
REQ-015 IDLE: start=1 -> RUN on that edge; operand register <= data, accumulator <= 0, beat counter <= 0; start=0 -> stay in IDLE.
REQ-016 RUN, each edge: accumulator += popcount of the next BITS_PER_CYCLE operand bits, LSB first; operand shifts right by BITS_PER_CYCLE; beat counter +1.
REQ-017 RUN lasts exactly WIDTH/BITS_PER_CYCLE edges; the final beat's edge loads count with the complete sum and moves the FSM to DONE.
REQ-018 Latency: start accepted at edge k -> done=1 and count valid after edge k+WIDTH/BITS_PER_CYCLE; 32 cycles at the defaults, 8 with BITS_PER_CYCLE=4.
REQ-019 Accumulator and count are CW bits wide; no overflow or truncation is permitted; the all-ones word yields WIDTH.
REQ-020 start is ignored in RUN and DONE; no queuing; a new word is accepted only from IDLE.
REQ-021 abort=1 in RUN -> IDLE on that edge; count keeps its previous value; done is not asserted; abort wins over the final-beat transition on the same edge.
REQ-022 abort is ignored in IDLE and DONE.
REQ-023 DONE holds done=1 and count stable until ack=1; that edge moves the FSM to IDLE; start on the same edge is ignored.
REQ-024 count changes only on the REQ-017 edge and at reset; it holds in IDLE, RUN and DONE otherwise.
REQ-025 Internal operand register, accumulator and beat counter SHALL NOT be externally visible.

Reset
REQ-026 reset=1 at a rising edge -> state IDLE, count=0, accumulator=0, beat counter=0, operand register=0; ready=1, busy=0, done=0 after that edge.
REQ-027 reset has priority over start, abort and ack, and over every state including mid-RUN and DONE.
REQ-028 An operation interrupted by reset produces no result; the first start after reset is accepted normally.

Verification
REQ-029 Defaults, data=0x00000000, start pulse -> busy for 32 cycles, then done=1, count=0.
REQ-030 data=0xFFFFFFFF -> count=32 (6'b100000); then data=0xA5A5A5A5 -> count=16; then 0x80000001 -> count=2; ack each result.
REQ-031 Start 0xFFFFFFFF, change data and pulse start again during RUN -> both ignored, result 32; hold done 5 cycles without ack -> count and done stable; ack -> ready next cycle.
REQ-032 After a completed count of 16, start 0xFFFFFFFF and abort at beat 10 -> IDLE next cycle, done never asserted, count stays 16; abort on the final beat -> same behaviour.
REQ-033 reset asserted at beat 20 of RUN and separately while in DONE -> after the edge ready=1, count=0, done=0; a following start of 0x0000000F -> count=4.
REQ-034 BITS_PER_CYCLE=4, data=0xF0F0F0F0 -> done after exactly 8 cycles, count=16.

Source files
------------

// File: rtl/ones_count_if.sv
// ones_count_if: request/result handshake between a producer of operand words and the ones counter
//   start, data, abort, ack : master -> slave (request side)
//   ready, busy, done, count: slave -> master (state and result)
interface ones_count_if #(
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(WIDTH + 1);
    logic             start;
    logic [WIDTH-1:0] data;
    logic             abort;
    logic             ack;
    logic             ready;
    logic             busy;
    logic             done;
    logic [CW-1:0]    count;
    modport master (output start, data, abort, ack, input ready, busy, done, count);
    modport slave  (input start, data, abort, ack, output ready, busy, done, count);
endinterface

// File: rtl/ones_count_ctrl.sv
// ones_count_ctrl: multi-cycle population count of a WIDTH-bit word, BITS_PER_CYCLE bits per beat
//   clk   : clock, all state changes on its rising edge
//   reset : synchronous active-high reset
//   ctl   : slave side of ones_count_if (start/data/abort/ack in, ready/busy/done/count out)
module ones_count_ctrl #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    ones_count_if.slave  ctl
);
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int BEATS = WIDTH / BITS_PER_CYCLE;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [CW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [CW-1:0]    beat_sum;
    logic             last_beat;

    // Running total including the low BITS_PER_CYCLE bits of the shifting operand.
    always_comb begin
        beat_sum = acc_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            beat_sum = beat_sum + CW'(op_q[i]);
    end

    assign last_beat = beat_q == BW'(BEATS - 1);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (ctl.start) begin
                state_d = RUN;
                op_d    = ctl.data;
                acc_d   = '0;
                beat_d  = '0;
            end
            // abort outranks the final beat, so an aborted word never reaches count
            RUN: if (ctl.abort) begin
                state_d = IDLE;
            end else begin
                op_d   = op_q >> BITS_PER_CYCLE;
                acc_d  = beat_sum;
                beat_d = beat_q + BW'(1);
                if (last_beat) begin
                    count_d = beat_sum;
                    state_d = DONE;
                end
            end
            DONE: if (ctl.ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            beat_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            count_q <= count_d;
        end
    end

    assign ctl.ready = state_q == IDLE;
    assign ctl.busy  = state_q == RUN;
    assign ctl.done  = state_q == DONE;
    assign ctl.count = count_q;
endmodule

// File: tb/tb_ones_count_ctrl.sv
// tb_ones_count_ctrl: scoreboard bench for ones_count_ctrl at 1 and 4 bits per cycle
module tb_ones_count_ctrl;
    logic clk = 1'b0;
    logic reset;
    int vectors = 0;
    int errors = 0;
    logic [5:0] exp_q[$];
    logic [5:0] exp;
    int cyc;

    always #5 clk = ~clk;

    ones_count_if #(.WIDTH(32)) bus ();
    ones_count_if #(.WIDTH(32)) bus4 ();

    ones_count_ctrl #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (.clk(clk), .reset(reset), .ctl(bus.slave));
    ones_count_ctrl #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .reset(reset), .ctl(bus4.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_word(input logic [31:0] w, input logic [5:0] e, input bit push);
        bus.start = 1'b1;
        bus.data  = w;
        tick();
        bus.start = 1'b0;
        bus.data  = $urandom;
        if (push) exp_q.push_back(e);
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (bus.done !== 1'b1 && c < 100) begin
            tick();
            c++;
        end
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if ({bus.ready, bus.busy, bus.done, bus.count} !== {3'b100, 6'd0}) begin
            errors++;
            $display("FAIL reset_state: rdy/bsy/dn/cnt=%b%b%b/%0d want 100/0", bus.ready, bus.busy, bus.done, bus.count);
        end
        vectors++;
        if ({bus4.ready, bus4.busy, bus4.done, bus4.count} !== {3'b100, 6'd0}) begin
            errors++;
            $display("FAIL reset_state4: rdy/bsy/dn/cnt=%b%b%b/%0d want 100/0", bus4.ready, bus4.busy, bus4.done, bus4.count);
        end
    endtask

    task automatic test_zero();
        start_word(32'h0, 6'd0, 1'b1);
        vectors++;
        if ({bus.ready, bus.busy, bus.done} !== 3'b010) begin
            errors++;
            $display("FAIL zero_busy: rdy/bsy/dn=%b%b%b want 010", bus.ready, bus.busy, bus.done);
        end
        wait_done(cyc);
        vectors++;
        if (cyc != 32) begin
            errors++;
            $display("FAIL zero_latency: got %0d cycles want 32", cyc);
        end
        exp = exp_q.pop_front();
        vectors++;
        if (bus.count !== exp) begin
            errors++;
            $display("FAIL zero_count: got %0d want %0d", bus.count, exp);
        end
        do_ack();
        vectors++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL zero_ack: ready=%b done=%b want 1 0", bus.ready, bus.done);
        end
    endtask

    task automatic test_patterns();
        logic [31:0] words[3] = '{32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'h8000_0001};
        logic [5:0]  cnts[3]  = '{6'd32, 6'd16, 6'd2};
        for (int i = 0; i < 3; i++) begin
            start_word(words[i], cnts[i], 1'b1);
            wait_done(cyc);
            vectors++;
            if (cyc != 32) begin
                errors++;
                $display("FAIL pattern_latency[%0d]: got %0d cycles want 32", i, cyc);
            end
            exp = exp_q.pop_front();
            vectors++;
            if (bus.count !== exp) begin
                errors++;
                $display("FAIL pattern_count[%0d]: got %0d want %0d", i, bus.count, exp);
            end
            do_ack();
        end
    endtask

    task automatic test_ignore_start();
        start_word(32'hFFFF_FFFF, 6'd32, 1'b1);
        repeat (3) tick();
        bus.data  = 32'h0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(cyc);
        vectors++;
        if (cyc != 28) begin
            errors++;
            $display("FAIL ignore_latency: got %0d remaining cycles want 28", cyc);
        end
        exp = exp_q.pop_front();
        vectors++;
        if (bus.count !== exp) begin
            errors++;
            $display("FAIL ignore_count: got %0d want %0d", bus.count, exp);
        end
        for (int i = 0; i < 5; i++) begin
            bus.abort = (i == 1);
            bus.start = (i == 3);
            tick();
            vectors++;
            if (bus.done !== 1'b1 || bus.count !== 6'd32) begin
                errors++;
                $display("FAIL hold_done[%0d]: done=%b count=%0d want 1 32", i, bus.done, bus.count);
            end
        end
        bus.abort = 1'b0;
        bus.start = 1'b1;
        do_ack();
        bus.start = 1'b0;
        vectors++;
        if (bus.ready !== 1'b1 || bus.count !== 6'd32) begin
            errors++;
            $display("FAIL ack_with_start: ready=%b count=%0d want 1 32", bus.ready, bus.count);
        end
        tick();
        vectors++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL ack_start_ignored: ready=%b want 1", bus.ready);
        end
    endtask

    task automatic test_abort();
        bit saw_done;
        start_word(32'hA5A5_A5A5, 6'd16, 1'b1);
        wait_done(cyc);
        exp = exp_q.pop_front();
        vectors++;
        if (bus.count !== exp) begin
            errors++;
            $display("FAIL abort_pre_count: got %0d want %0d", bus.count, exp);
        end
        do_ack();
        for (int b = 0; b < 2; b++) begin
            saw_done = 1'b0;
            start_word(32'hFFFF_FFFF, 6'd0, 1'b0);
            repeat (b ? 31 : 9) begin
                tick();
                saw_done |= bus.done;
            end
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
            saw_done |= bus.done;
            tick();
            saw_done |= bus.done;
            vectors++;
            if (bus.ready !== 1'b1 || saw_done || bus.count !== 6'd16) begin
                errors++;
                $display("FAIL abort[%0s]: ready=%b saw_done=%b count=%0d want 1 0 16", b ? "final" : "beat10", bus.ready, saw_done, bus.count);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_word(32'hFFFF_FFFF, 6'd0, 1'b0);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({bus.ready, bus.done, bus.count} !== {2'b10, 6'd0}) begin
            errors++;
            $display("FAIL reset_run: ready=%b done=%b count=%0d want 1 0 0", bus.ready, bus.done, bus.count);
        end
        start_word(32'h0000_000F, 6'd4, 1'b1);
        wait_done(cyc);
        exp = exp_q.pop_front();
        vectors++;
        if (cyc != 32 || bus.count !== exp) begin
            errors++;
            $display("FAIL after_reset_run: cycles=%0d count=%0d want 32 %0d", cyc, bus.count, exp);
        end
        bus.ack = 1'b1;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        bus.ack = 1'b0;
        vectors++;
        if ({bus.ready, bus.done, bus.count} !== {2'b10, 6'd0}) begin
            errors++;
            $display("FAIL reset_done: ready=%b done=%b count=%0d want 1 0 0", bus.ready, bus.done, bus.count);
        end
        start_word(32'h0000_000F, 6'd4, 1'b1);
        wait_done(cyc);
        exp = exp_q.pop_front();
        vectors++;
        if (cyc != 32 || bus.count !== exp) begin
            errors++;
            $display("FAIL after_reset_done: cycles=%0d count=%0d want 32 %0d", cyc, bus.count, exp);
        end
        do_ack();
    endtask

    task automatic test_bpc4();
        bus4.start = 1'b1;
        bus4.data  = 32'hF0F0_F0F0;
        tick();
        bus4.start = 1'b0;
        bus4.data  = 32'h0;
        exp_q.push_back(6'd16);
        cyc = 0;
        while (bus4.done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        vectors++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL bpc4_latency: got %0d cycles want 8", cyc);
        end
        exp = exp_q.pop_front();
        vectors++;
        if (bus4.count !== exp) begin
            errors++;
            $display("FAIL bpc4_count: got %0d want %0d", bus4.count, exp);
        end
        bus4.ack = 1'b1;
        tick();
        bus4.ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            bus.abort = (i == 0);
            start_word(w, 6'($countones(w)), 1'b1);
            bus.abort = 1'b0;
            wait_done(cyc);
            exp = exp_q.pop_front();
            vectors++;
            if (cyc != 32 || bus.count !== exp) begin
                errors++;
                $display("FAIL b2b[%0d] %h: cycles=%0d count=%0d want 32 %0d", i, w, cyc, bus.count, exp);
            end
            do_ack();
        end
    endtask

    initial begin
        reset = 1'b1;
        {bus.start, bus.abort, bus.ack} = 3'b000;
        {bus4.start, bus4.abort, bus4.ack} = 3'b000;
        bus.data  = '0;
        bus4.data = '0;
        test_reset();
        test_zero();
        test_patterns();
        test_ignore_start();
        test_abort();
        test_reset_mid();
        test_bpc4();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
